// File: rtl/uart_tx_if.sv
// Transmit request/status bundle between the control logic and the UART transmitter.
// The master drives the request and tick; the transmitter (slave) drives the line and status.
interface uart_tx_if #(
    parameter int NB_BIT = 8
);
    logic              tx_start;
    logic              s_tick;
    logic [NB_BIT-1:0] din;
    logic              tx;
    logic              tx_busy;
    logic              tx_done_tick;

    modport master (
        output tx_start, s_tick, din,
        input  tx, tx_busy, tx_done_tick
    );

    modport slave (
        input  tx_start, s_tick, din,
        output tx, tx_busy, tx_done_tick
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, NB_BIT data bits LSB first, optional parity, stop period.
// Bit timing is 16 s_tick pulses per bit; the stop period lasts SB_TICK pulses.
module uart_tx #(
    parameter int NB_BIT     = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset,
    uart_tx_if.slave   bus,
    output logic [2:0] dbg_state
);
    localparam int TICK_MAX = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int TW       = $clog2(TICK_MAX);
    localparam int BW       = $clog2(NB_BIT);

    localparam logic [TW-1:0] BIT_TICK_LAST  = TW'(15);
    localparam logic [TW-1:0] STOP_TICK_LAST = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST       = BW'(NB_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [NB_BIT-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;

    // Parity is taken from the word at acceptance, so it survives the shifting.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.tx_start) begin
                    shift_d = bus.din;
                    par_d   = (^bus.din) ^ (PARITY_ODD != 0);
                    tick_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bus.s_tick) begin
                    if (tick_q == BIT_TICK_LAST) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (bus.s_tick) begin
                    if (tick_q == BIT_TICK_LAST) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        if (bit_q == BIT_LAST) begin
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bus.s_tick) begin
                    if (tick_q == BIT_TICK_LAST) begin
                        tick_d  = '0;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bus.s_tick) begin
                    if (tick_q == STOP_TICK_LAST) begin
                        tick_d  = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The pin level is derived from the next state so it changes on the same edge.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx           = tx_q;
    assign bus.tx_busy      = (state_q != IDLE);
    assign bus.tx_done_tick = done_q;
    assign dbg_state        = state_q;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations share one stimulus stream and are checked
// every cycle against a tick-count model of the frame, plus fixed expected bit patterns.
module tb_uart_tx;
    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tx_start = 1'b0;
    logic          s_tick = 1'b1;
    logic [NB-1:0] din = '0;
    int            tick_period = 1;
    int            tick_cnt = 0;
    int            n_pass = 0;
    int            n_total = 0;

    // configuration of dut0 / dut1 / dut2
    int sb_a   [3] = '{16, 16, 32};
    int pen_a  [3] = '{0, 1, 1};
    int podd_a [3] = '{0, 0, 1};

    // behavioural model: busy flag, ticks consumed since acceptance, latched word
    logic          m_busy [3] = '{1'b0, 1'b0, 1'b0};
    logic          m_done [3] = '{1'b0, 1'b0, 1'b0};
    int            m_t    [3] = '{0, 0, 0};
    logic [NB-1:0] m_word [3];

    logic [2:0] obs_tx, obs_busy, obs_done;
    logic [2:0] dbg0, dbg1, dbg2;

    always #5 clk = ~clk;

    uart_tx_if #(.NB_BIT(NB)) bus0 ();
    uart_tx_if #(.NB_BIT(NB)) bus1 ();
    uart_tx_if #(.NB_BIT(NB)) bus2 ();

    assign bus0.tx_start = tx_start;
    assign bus0.s_tick   = s_tick;
    assign bus0.din      = din;
    assign bus1.tx_start = tx_start;
    assign bus1.s_tick   = s_tick;
    assign bus1.din      = din;
    assign bus2.tx_start = tx_start;
    assign bus2.s_tick   = s_tick;
    assign bus2.din      = din;

    uart_tx #(.NB_BIT(NB), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0))
        dut0 (.clk(clk), .reset(reset), .bus(bus0.slave), .dbg_state(dbg0));
    uart_tx #(.NB_BIT(NB), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0))
        dut1 (.clk(clk), .reset(reset), .bus(bus1.slave), .dbg_state(dbg1));
    uart_tx #(.NB_BIT(NB), .SB_TICK(32), .PARITY_EN(1), .PARITY_ODD(1))
        dut2 (.clk(clk), .reset(reset), .bus(bus2.slave), .dbg_state(dbg2));

    assign obs_tx   = {bus2.tx, bus1.tx, bus0.tx};
    assign obs_busy = {bus2.tx_busy, bus1.tx_busy, bus0.tx_busy};
    assign obs_done = {bus2.tx_done_tick, bus1.tx_done_tick, bus0.tx_done_tick};

    function automatic int frame_len(int i);
        return (1 + NB + pen_a[i]) * 16 + sb_a[i];
    endfunction

    function automatic logic exp_tx(int i);
        int seg;
        if (!m_busy[i]) return 1'b1;
        seg = m_t[i] / 16;
        if (seg == 0) return 1'b0;
        if (seg <= NB) return m_word[i][seg-1];
        if (pen_a[i] != 0 && seg == NB + 1) return (^m_word[i]) ^ (podd_a[i] != 0);
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            m_done[i] = 1'b0;
            if (!reset) begin
                m_busy[i] = 1'b0;
            end else if (!m_busy[i]) begin
                if (tx_start) begin
                    m_busy[i] = 1'b1;
                    m_word[i] = din;
                    m_t[i]    = 0;
                end
            end else if (s_tick) begin
                m_t[i] = m_t[i] + 1;
                if (m_t[i] == frame_len(i)) begin
                    m_busy[i] = 1'b0;
                    m_done[i] = 1'b1;
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        tick_cnt = tick_cnt + 1;
        s_tick = ((tick_cnt % tick_period) == 0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tx_start = 1'b1;
        din = NB'($urandom);
        for (int k = 0; k < 3; k++) begin
            cycle();
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if ({obs_tx[i], obs_busy[i], obs_done[i]} !== 3'b100)
                    $display("FAIL reset_hold dut%0d cyc %0d: tx/busy/done got %b%b%b want 100",
                             i, k, obs_tx[i], obs_busy[i], obs_done[i]);
                else n_pass++;
            end
        end
        reset = 1'b1;
        tx_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if ({obs_tx[i], obs_busy[i], obs_done[i]} !== 3'b100)
                    $display("FAIL reset_release dut%0d cyc %0d: tx/busy/done got %b%b%b want 100",
                             i, k, obs_tx[i], obs_busy[i], obs_done[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_default_frame();
        logic [0:9] seq_a5 = 10'b0101001011;
        int done_at [3] = '{-1, -1, -1};
        int n_done0 = 0;
        int busy0 = 0;
        tick_period = 1;
        tick_cnt = 0;
        din = 8'hA5;
        tx_start = 1'b1;
        for (int k = 0; k < 300; k++) begin
            cycle();
            if (k == 0) tx_start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if ({obs_tx[i], obs_busy[i], obs_done[i]} !== {exp_tx(i), m_busy[i], m_done[i]})
                    $display("FAIL default_frame dut%0d cyc %0d: tx/busy/done got %b%b%b want %b%b%b",
                             i, k, obs_tx[i], obs_busy[i], obs_done[i], exp_tx(i), m_busy[i], m_done[i]);
                else n_pass++;
                if (obs_done[i] === 1'b1 && done_at[i] < 0) done_at[i] = k;
            end
            if (obs_done[0] === 1'b1) n_done0++;
            if (obs_busy[0] === 1'b1) busy0++;
            if (k % 16 == 8 && k < 160) begin
                n_total++;
                if (obs_tx[0] !== seq_a5[k/16])
                    $display("FAIL a5_level bit %0d: tx got %b want %b", k/16, obs_tx[0], seq_a5[k/16]);
                else n_pass++;
            end
            if (k == 152) begin
                n_total++;
                if (obs_tx[1] !== 1'b0) $display("FAIL a5_even_parity: tx got %b want 0", obs_tx[1]);
                else n_pass++;
                n_total++;
                if (obs_tx[2] !== 1'b1) $display("FAIL a5_odd_parity: tx got %b want 1", obs_tx[2]);
                else n_pass++;
            end
        end
        n_total++;
        if (n_done0 != 1 || done_at[0] != 160)
            $display("FAIL default_done: pulses %0d at %0d, want 1 at 160", n_done0, done_at[0]);
        else n_pass++;
        n_total++;
        if (busy0 != 160) $display("FAIL default_busy_len: got %0d want 160", busy0);
        else n_pass++;
        n_total++;
        if (done_at[1] != 176) $display("FAIL parity_frame_len: done at %0d want 176", done_at[1]);
        else n_pass++;
        n_total++;
        if (done_at[2] != 192) $display("FAIL odd_sb32_frame_len: done at %0d want 192", done_at[2]);
        else n_pass++;
    endtask

    task automatic test_parity_07();
        tick_period = 1;
        tick_cnt = 0;
        din = 8'h07;
        tx_start = 1'b1;
        for (int k = 0; k < 200; k++) begin
            cycle();
            if (k == 0) tx_start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if ({obs_tx[i], obs_busy[i], obs_done[i]} !== {exp_tx(i), m_busy[i], m_done[i]})
                    $display("FAIL parity_07 dut%0d cyc %0d: tx/busy/done got %b%b%b want %b%b%b",
                             i, k, obs_tx[i], obs_busy[i], obs_done[i], exp_tx(i), m_busy[i], m_done[i]);
                else n_pass++;
            end
            if (k == 152) begin
                n_total++;
                if (obs_tx[1] !== 1'b1) $display("FAIL p07_even_parity: tx got %b want 1", obs_tx[1]);
                else n_pass++;
                n_total++;
                if (obs_tx[2] !== 1'b0) $display("FAIL p07_odd_parity: tx got %b want 0", obs_tx[2]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_sparse();
        logic [0:7] bits_3c = 8'b00111100;
        int stop_high = 0;
        int done_at [3] = '{-1, -1, -1};
        tick_period = 4;
        tick_cnt = 0;
        s_tick = 1'b0;
        din = 8'h3C;
        tx_start = 1'b1;
        for (int k = 0; k < 800; k++) begin
            cycle();
            if (k == 0) tx_start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if ({obs_tx[i], obs_busy[i], obs_done[i]} !== {exp_tx(i), m_busy[i], m_done[i]})
                    $display("FAIL sparse dut%0d cyc %0d: tx/busy/done got %b%b%b want %b%b%b",
                             i, k, obs_tx[i], obs_busy[i], obs_done[i], exp_tx(i), m_busy[i], m_done[i]);
                else n_pass++;
                if (obs_done[i] === 1'b1 && done_at[i] < 0) done_at[i] = k;
            end
            if (k >= 64 && k < 576 && k % 64 == 32) begin
                n_total++;
                if (obs_tx[2] !== bits_3c[k/64 - 1])
                    $display("FAIL sparse_bit %0d: tx got %b want %b", k/64 - 1, obs_tx[2], bits_3c[k/64 - 1]);
                else n_pass++;
            end
            if (k >= 640 && k < 768 && obs_tx[2] === 1'b1 && obs_busy[2] === 1'b1) stop_high++;
        end
        n_total++;
        if (stop_high != 128) $display("FAIL sparse_stop_len: got %0d want 128", stop_high);
        else n_pass++;
        n_total++;
        if (done_at[2] != 768) $display("FAIL sparse_done_dut2: at %0d want 768", done_at[2]);
        else n_pass++;
        n_total++;
        if (done_at[0] != 640) $display("FAIL sparse_done_dut0: at %0d want 640", done_at[0]);
        else n_pass++;
        tick_period = 1;
    endtask

    task automatic test_handshake();
        logic [NB-1:0] w = NB'($urandom_range(0, 255));
        int n_done0 = 0;
        tick_period = 1;
        tick_cnt = 0;
        din = w;
        tx_start = 1'b1;
        for (int k = 0; k < 300; k++) begin
            cycle();
            if (k == 0) tx_start = 1'b0;
            if (k == 50) begin tx_start = 1'b1; din = 8'hFF; end
            if (k == 51) tx_start = 1'b0;
            if (k > 51) din = NB'($urandom);
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if ({obs_tx[i], obs_busy[i], obs_done[i]} !== {exp_tx(i), m_busy[i], m_done[i]})
                    $display("FAIL ignore_start dut%0d cyc %0d: tx/busy/done got %b%b%b want %b%b%b",
                             i, k, obs_tx[i], obs_busy[i], obs_done[i], exp_tx(i), m_busy[i], m_done[i]);
                else n_pass++;
            end
            if (obs_done[0] === 1'b1) n_done0++;
            if (k >= 16 && k < 144 && k % 16 == 8) begin
                n_total++;
                if (obs_tx[0] !== w[k/16 - 1])
                    $display("FAIL ignore_start_bit %0d: tx got %b want %b", k/16 - 1, obs_tx[0], w[k/16 - 1]);
                else n_pass++;
            end
        end
        n_total++;
        if (n_done0 != 1) $display("FAIL ignore_start_done: pulses %0d want 1", n_done0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [NB-1:0] b2b = 8'h55;
        int n_done0 = 0;
        tick_period = 1;
        tick_cnt = 0;
        din = NB'($urandom);
        tx_start = 1'b1;
        for (int k = 0; k < 500; k++) begin
            cycle();
            if (k == 0) din = b2b;
            if (k == 193) tx_start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if ({obs_tx[i], obs_busy[i], obs_done[i]} !== {exp_tx(i), m_busy[i], m_done[i]})
                    $display("FAIL back_to_back dut%0d cyc %0d: tx/busy/done got %b%b%b want %b%b%b",
                             i, k, obs_tx[i], obs_busy[i], obs_done[i], exp_tx(i), m_busy[i], m_done[i]);
                else n_pass++;
            end
            if (obs_done[0] === 1'b1) n_done0++;
            if (k == 160) begin
                n_total++;
                if ({obs_tx[0], obs_busy[0], obs_done[0]} !== 3'b101)
                    $display("FAIL b2b_done_cycle: tx/busy/done got %b%b%b want 101",
                             obs_tx[0], obs_busy[0], obs_done[0]);
                else n_pass++;
            end
            if (k == 161) begin
                n_total++;
                if ({obs_tx[0], obs_busy[0], obs_done[0]} !== 3'b010)
                    $display("FAIL b2b_second_start: tx/busy/done got %b%b%b want 010",
                             obs_tx[0], obs_busy[0], obs_done[0]);
                else n_pass++;
            end
            if (k >= 177 && k < 305 && (k - 161) % 16 == 8) begin
                n_total++;
                if (obs_tx[0] !== b2b[(k - 161)/16 - 1])
                    $display("FAIL b2b_bit %0d: tx got %b want %b", (k - 161)/16 - 1, obs_tx[0],
                             b2b[(k - 161)/16 - 1]);
                else n_pass++;
            end
        end
        n_total++;
        if (n_done0 != 2) $display("FAIL b2b_done_count: pulses %0d want 2", n_done0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [NB-1:0] w81 = 8'h81;
        int done_at0 = -1;
        tick_period = 1;
        tick_cnt = 0;
        din = NB'($urandom);
        tx_start = 1'b1;
        for (int k = 0; k < 100; k++) begin
            cycle();
            if (k == 0) tx_start = 1'b0;
            if (k == 72) reset = 1'b0;
            if (k == 73) begin
                reset = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    n_total++;
                    if ({obs_tx[i], obs_busy[i], obs_done[i]} !== 3'b100)
                        $display("FAIL mid_reset dut%0d: tx/busy/done got %b%b%b want 100",
                                 i, obs_tx[i], obs_busy[i], obs_done[i]);
                    else n_pass++;
                end
            end
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if ({obs_tx[i], obs_busy[i], obs_done[i]} !== {exp_tx(i), m_busy[i], m_done[i]})
                    $display("FAIL mid_reset_trace dut%0d cyc %0d: tx/busy/done got %b%b%b want %b%b%b",
                             i, k, obs_tx[i], obs_busy[i], obs_done[i], exp_tx(i), m_busy[i], m_done[i]);
                else n_pass++;
            end
        end
        tick_cnt = 0;
        din = w81;
        tx_start = 1'b1;
        for (int k = 0; k < 220; k++) begin
            cycle();
            if (k == 0) tx_start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if ({obs_tx[i], obs_busy[i], obs_done[i]} !== {exp_tx(i), m_busy[i], m_done[i]})
                    $display("FAIL after_reset dut%0d cyc %0d: tx/busy/done got %b%b%b want %b%b%b",
                             i, k, obs_tx[i], obs_busy[i], obs_done[i], exp_tx(i), m_busy[i], m_done[i]);
                else n_pass++;
            end
            if (obs_done[0] === 1'b1 && done_at0 < 0) done_at0 = k;
            if (k >= 16 && k < 144 && k % 16 == 8) begin
                n_total++;
                if (obs_tx[0] !== w81[k/16 - 1])
                    $display("FAIL after_reset_bit %0d: tx got %b want %b", k/16 - 1, obs_tx[0], w81[k/16 - 1]);
                else n_pass++;
            end
        end
        n_total++;
        if (done_at0 != 160) $display("FAIL after_reset_done: at %0d want 160", done_at0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_default_frame();
        test_parity_07();
        test_sparse();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART serial transmitter, the transmit-side counterpart of the team's oversampling UART receiver.
- Serialises one NB_BIT word per request as: start bit, data LSB first, optional parity bit, stop period.
- Timing comes from the shared baud-rate generator's s_tick pulse: 16 ticks per bit, SB_TICK ticks for the stop period.
- Sits between the ALU/interface control logic and the tx pin.

Parameters:
NB_BIT, 8, number of data bits per frame (5..9)
SB_TICK, 16, s_tick count for the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2)
PARITY_EN, 0, 1 inserts a parity bit after the data bits
PARITY_ODD, 0, with PARITY_EN=1: 0 = even parity, 1 = odd parity

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
tx_start  input  1  request to send din; accepted only in IDLE
s_tick  input  1  single-cycle baud oversampling tick (16x bit rate)
din  input  NB_BIT  word to transmit; sampled only when tx_start is accepted
tx  output  1  serial line, registered, idles high
tx_busy  output  1  high while a frame is in progress
tx_done_tick  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset (reset=0 at rising clk):
  - state=IDLE; tick counter, bit counter and data shift register cleared.
  - Outputs: tx=1, tx_busy=0, tx_done_tick=0.
  - Applies mid-frame too: frame aborted, tx=1 after that edge, no tx_done_tick.
- Tick counter width: ceil(log2(max(16,SB_TICK))). Bit counter width: ceil(log2(NB_BIT)).
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1.
  - On tx_start=1: latch din into shift register, clear tick counter, go to START.
  - tx=0 and tx_busy=1 take effect on that same edge.
- START: tx=0.
  - Each s_tick increments the tick counter.
  - On the s_tick with counter==15: clear counter and bit counter, go to DATA.
- DATA: tx=shift_reg[0].
  - On the s_tick with counter==15: clear counter, shift register right by 1.
  - If bit counter==NB_BIT-1: go to PARITY when PARITY_EN=1, else STOP. Otherwise increment bit counter.
- PARITY: tx = XOR of the latched word (captured at acceptance, not the shifted value), inverted when PARITY_ODD=1.
  - Lasts 16 s_ticks, then STOP.
- STOP: tx=1.
  - On the s_tick with counter==SB_TICK-1: go to IDLE, assert tx_done_tick for the following single cycle.
- tx value is registered; it changes on the same edge as the state/shift change, so there are no combinational glitches on the pin.
- tx_busy = (state != IDLE). It is 0 in the cycle tx_done_tick is high.
- tx_done_tick is high only in the first IDLE cycle after STOP; never high otherwise.
- Boundary conditions:
  - tx_start while busy: ignored, no queuing. din changes while busy: ignored.
  - tx_start in the same cycle as tx_done_tick: accepted (back-to-back frames, no idle gap beyond that cycle).
  - s_tick high every cycle: legal, each cycle counts.
  - s_tick low: counters hold, tx holds.
- Frame length: (1 + NB_BIT + PARITY_EN)*16 + SB_TICK s_ticks. Default: 160 ticks.
- Counters wrap only via explicit clear; no overflow is reachable.

Test Plan:
- Reset check: reset=0 for 3 cycles with tx_start=1 -> tx=1, tx_busy=0, tx_done_tick=0 throughout; no frame starts after release until a new tx_start.
- Default frame, s_tick every cycle, din=0xA5, 1-cycle tx_start -> tx sequence 0,1,0,1,0,0,1,0,1,1, each level exactly 16 cycles; tx_done_tick pulses exactly once, 160 cycles after acceptance; tx_busy high for those 160 cycles.
- Parity: PARITY_EN=1, din=0xA5 -> parity bit 0 (even) and 1 with PARITY_ODD=1; din=0x07, even -> parity 1; frame 176 ticks.
- Sparse ticks and stop length: s_tick every 4 cycles, SB_TICK=32, din=0x3C -> each bit 64 cycles, stop high 128 cycles, data bits 0,0,1,1,1,1,0,0.
- Handshake: tx_start pulsed mid-frame with din=0xFF -> ignored, original frame intact. tx_start held high across tx_done_tick with din=0x55 -> second frame's start bit begins on the tx_done_tick cycle edge, no gap.
- Reset mid-frame during DATA bit 3 -> tx=1 on next edge, no tx_done_tick; a new tx_start with din=0x81 sends a clean complete frame.
